blinker_sequencer: RTL and testbench

- Controller that sequences the free-running tick-counter datapath into programmable LED blink bursts.
- Owns an internal prescaler with the same wrap-at-terminal-value semantics as the block's tick counter.
- An FSM counts prescaler ticks to time ON and OFF phases for a requested number of blinks, then reports completion.
- Sits between the board-level control logic (start/abort) and the LED pin.

---
 rtl/blinker_sequencer.sv | 122 ++++++++++++
 tb/tb_blinker_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blinker_sequencer.sv
// Blink-burst controller: a wrap-at-TICK_MAX prescaler times ON/OFF phases
// for a latched number of blinks, then pulses done for one cycle.
module blinker_sequencer #(
    parameter int unsigned CNT_W    = 26,
    parameter int unsigned TICK_MAX = 52428800,
    parameter int unsigned LEN_W    = 4
) (
    input  logic             system1000,
    input  logic             system1000_rstn,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [LEN_W-1:0] count_i,
    input  logic [LEN_W-1:0] on_len_i,
    input  logic [LEN_W-1:0] off_len_i,
    output logic             led_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             tick_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TICK_TERM = CNT_W'(TICK_MAX);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   presc;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   on_len;
    logic [LEN_W-1:0]   off_len;
    logic [LEN_W-1:0]   phase;
    logic               active;
    logic               tick;
    logic [LEN_W-1:0]   on_eff;
    logic [LEN_W-1:0]   off_eff;

    // Zero-length phases are stretched to one tick.
    always_comb begin
        on_eff  = (on_len_i  == '0) ? LEN_ONE : on_len_i;
        off_eff = (off_len_i == '0) ? LEN_ONE : off_len_i;
    end

    assign active = (state == S_ON) || (state == S_OFF);
    assign tick   = active && (presc == TICK_TERM);

    assign led_o  = (state == S_ON);
    assign busy_o = (state != S_IDLE);
    assign done_o = (state == S_DONE);
    assign tick_o = tick;

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state     <= S_IDLE;
            presc     <= '0;
            remaining <= '0;
            on_len    <= '0;
            off_len   <= '0;
            phase     <= '0;
        end else if (abort_i) begin
            state <= S_IDLE;
            presc <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    presc <= '0;
                    if (start_i) begin
                        if (count_i != '0) begin
                            remaining <= count_i;
                            on_len    <= on_eff;
                            off_len   <= off_eff;
                            phase     <= on_eff;
                            state     <= S_ON;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_ON: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        if (phase == LEN_ONE) begin
                            phase <= off_len;
                            state <= S_OFF;
                        end else begin
                            phase <= phase - 1'b1;
                        end
                    end
                end
                S_OFF: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        if (phase == LEN_ONE) begin
                            if (remaining == LEN_ONE) begin
                                state <= S_DONE;
                            end else begin
                                remaining <= remaining - 1'b1;
                                phase     <= on_len;
                                state     <= S_ON;
                            end
                        end else begin
                            phase <= phase - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    presc <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    presc <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blinker_sequencer.sv
// Bench for blinker_sequencer: per-cycle output traces compared against a
// model built from phase lengths, blink counts and tick period arithmetic.
module tb_blinker_sequencer;

    localparam int unsigned T1 = 3;
    localparam int unsigned T2 = 37;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start, abort;
    logic [3:0] cnt, onl, offl;
    logic       led, busy, done, tick;

    logic       b_start, b_abort;
    logic [3:0] b_cnt, b_onl, b_offl;
    logic       b_led, b_busy, b_done, b_tick;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    blinker_sequencer #(.CNT_W(26), .TICK_MAX(T1), .LEN_W(4)) dut (
        .system1000(clk), .system1000_rstn(rstn), .start_i(start), .abort_i(abort),
        .count_i(cnt), .on_len_i(onl), .off_len_i(offl),
        .led_o(led), .busy_o(busy), .done_o(done), .tick_o(tick)
    );

    blinker_sequencer #(.CNT_W(6), .TICK_MAX(T2), .LEN_W(4)) dut_b (
        .system1000(clk), .system1000_rstn(rstn), .start_i(b_start), .abort_i(b_abort),
        .count_i(b_cnt), .on_len_i(b_onl), .off_len_i(b_offl),
        .led_o(b_led), .busy_o(b_busy), .done_o(b_done), .tick_o(b_tick)
    );

    // Expected {led,busy,done,tick} per cycle, starting with the first cycle after the start edge.
    task automatic model_build(input int unsigned c, input int unsigned on, input int unsigned off,
                               input int unsigned t);
        int unsigned on_e, off_e;
        exp_q.delete();
        on_e  = (on  == 0) ? 1 : on;
        off_e = (off == 0) ? 1 : off;
        for (int unsigned b = 0; b < c; b++) begin
            for (int unsigned i = 0; i < on_e * (t + 1); i++)
                exp_q.push_back({1'b1, 1'b1, 1'b0, (i % (t + 1)) == t});
            for (int unsigned i = 0; i < off_e * (t + 1); i++)
                exp_q.push_back({1'b0, 1'b1, 1'b0, (i % (t + 1)) == t});
        end
        exp_q.push_back(4'b0110);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] c, input logic [3:0] on, input logic [3:0] off);
        start = 1'b1; cnt = c; onl = on; offl = off;
        cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rstn = 1'b0; start = 1'b1; abort = 1'b0; cnt = 4'd5; onl = 4'd1; offl = 4'd1;
        b_start = 1'b0; b_abort = 1'b0; b_cnt = '0; b_onl = '0; b_offl = '0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            got = {led, busy, done, tick};
            n_cmp++;
            if (got !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=0000", i, got);
            end
        end
        @(negedge clk);
        rstn = 1'b1; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            got = {led, busy, done, tick};
            n_cmp++;
            if (got !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_release cyc=%0d got=%b exp=0000", i, got);
            end
        end
    endtask

    task automatic test_basic(input logic [3:0] c, input logic [3:0] on, input logic [3:0] off);
        logic [3:0] got, want;
        model_build(c, on, off, T1);
        launch(c, on, off);
        for (int i = 0; i < exp_q.size() + 2; i++) begin
            got  = {led, busy, done, tick};
            want = (i < exp_q.size()) ? exp_q[i] : 4'b0000;
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL basic c=%0d on=%0d off=%0d cyc=%0d got=%b exp=%b", c, on, off, i, got, want);
            end
            cycle();
        end
    endtask

    task automatic test_abort();
        logic [3:0] got, want;
        model_build(3, 2, 2, T1);
        launch(4'd3, 4'd2, 4'd2);
        for (int i = 0; i < 14; i++) begin
            got  = {led, busy, done, tick};
            want = (i <= 10) ? exp_q[i] : 4'b0000;
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL abort cyc=%0d got=%b exp=%b", i, got, want);
            end
            abort = (i == 10);
            cycle();
        end
        abort = 1'b0;
        start = 1'b1; abort = 1'b1; cnt = 4'd2; onl = 4'd1; offl = 4'd1;
        cycle();
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = {led, busy, done, tick};
            n_cmp++;
            if (got !== 4'b0000) begin
                n_bad++;
                $display("FAIL abort_with_start cyc=%0d got=%b exp=0000", i, got);
            end
            cycle();
        end
    endtask

    task automatic test_start_while_busy();
        logic [3:0] got, want;
        model_build(2, 2, 1, T1);
        launch(4'd2, 4'd2, 4'd1);
        for (int i = 0; i < exp_q.size() + 2; i++) begin
            got  = {led, busy, done, tick};
            want = (i < exp_q.size()) ? exp_q[i] : 4'b0000;
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL start_busy cyc=%0d got=%b exp=%b", i, got, want);
            end
            start = (i == 3);
            if (i == 3) begin cnt = 4'd7; onl = 4'd5; offl = 4'd6; end
            cycle();
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] got;
        launch(4'd2, 4'd2, 4'd2);
        repeat (5) cycle();
        #2 rstn = 1'b0;
        #1;
        got = {led, busy, done, tick};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_bad++;
            $display("FAIL async_reset got=%b exp=0000", got);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            got = {led, busy, done, tick};
            n_cmp++;
            if (got !== 4'b0000) begin
                n_bad++;
                $display("FAIL async_reset_after cyc=%0d got=%b exp=0000", i, got);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] got, want;
        int unsigned c, on, off;
        int len, ab;
        for (int it = 0; it < 12; it++) begin
            c = $urandom_range(0, 3); on = $urandom_range(0, 3); off = $urandom_range(0, 3);
            model_build(c, on, off, T1);
            len = exp_q.size();
            ab  = (len >= 3 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 2)) : -1;
            launch(4'(c), 4'(on), 4'(off));
            for (int i = 0; i < len + 2; i++) begin
                got = {led, busy, done, tick};
                if (ab >= 0 && i > ab) want = 4'b0000;
                else want = (i < len) ? exp_q[i] : 4'b0000;
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL random it=%0d c=%0d on=%0d off=%0d ab=%0d cyc=%0d got=%b exp=%b",
                             it, c, on, off, ab, i, got, want);
                end
                abort = (i == ab);
                start = (i < len - 1 && (ab < 0 || i < ab)) ? 1'($urandom_range(0, 1)) : 1'b0;
                cnt = 4'($urandom); onl = 4'($urandom); offl = 4'($urandom);
                cycle();
            end
            abort = 1'b0; start = 1'b0;
        end
    endtask

    task automatic test_long_tick();
        logic [3:0] got, want;
        model_build(1, 1, 1, T2);
        b_start = 1'b1; b_cnt = 4'd1; b_onl = 4'd1; b_offl = 4'd1;
        cycle();
        b_start = 1'b0;
        for (int i = 0; i < exp_q.size() + 2; i++) begin
            got  = {b_led, b_busy, b_done, b_tick};
            want = (i < exp_q.size()) ? exp_q[i] : 4'b0000;
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL long_tick cyc=%0d got=%b exp=%b", i, got, want);
            end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_basic(4'd2, 4'd2, 4'd1);
        test_basic(4'd1, 4'd0, 4'd0);
        test_basic(4'd0, 4'd3, 4'd3);
        test_basic(4'd15, 4'd1, 4'd1);
        test_abort();
        test_start_while_busy();
        test_async_reset();
        test_random();
        test_long_tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
